// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  // Widest operand the helpers handle; products use twice this.
  localparam int unsigned MaxW     = 64;
  localparam int unsigned ProdMaxW = 2 * MaxW;

  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  function automatic logic [ProdMaxW-1:0] neg2c(input logic [ProdMaxW-1:0] v);
    return ~v + ProdMaxW'(1);
  endfunction

  // Low w bits of the result hold |v| when sgn is set; the magnitude of -2^(w-1) still fits.
  function automatic logic [ProdMaxW-1:0] mag_of(input logic [MaxW-1:0] v,
                                                 input int unsigned   w,
                                                 input logic          sgn);
    logic [ProdMaxW-1:0] m;
    m = ProdMaxW'(v);
    if (sgn && v[w-1]) begin
      m = neg2c(m);
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_add_mult_seq_if.sv
// Operand/result bundle of the multiplier; signal directions named from the multiplier's view.
interface shift_add_mult_seq_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                      i_start;
  logic                      i_signed;
  logic [DATA_WIDTH-1:0]     i_a;
  logic [DATA_WIDTH-1:0]     i_b;
  logic                      o_busy;
  logic                      o_done;
  logic [2*DATA_WIDTH-1:0]   o_product;

  modport master (
    output i_start, i_signed, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_signed, i_a, i_b,
    output o_busy, o_done, o_product
  );

endinterface

// File: rtl/sa_step.sv
// One shift-and-add iteration: conditional add of B, then {ACC, A} shifted right by one.
module sa_step #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH:0]   i_acc,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH:0]   o_acc,
  output logic [DATA_WIDTH-1:0] o_a
);

  logic [DATA_WIDTH:0] w_sum;

  always_comb begin
    w_sum = i_acc + (i_a[0] ? {1'b0, i_b} : '0);
    o_acc = {1'b0, w_sum[DATA_WIDTH:1]};
    o_a   = {w_sum[0], i_a[DATA_WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier: W iterations on magnitudes, then a sign-fix cycle.
module shift_add_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGNED_EN  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  shift_add_mult_seq_if.slave  io_bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned PW   = 2 * DATA_WIDTH;
  localparam int unsigned CntW = cnt_w(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  state_e          r_state, w_state_nxt;
  logic [W:0]      r_acc, w_acc_nxt;
  logic [W-1:0]    r_a, w_a_nxt;
  logic [W-1:0]    r_b, w_b_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_neg, w_neg_nxt;
  logic [PW-1:0]   r_product, w_product_nxt;
  logic            r_done, w_done_nxt;

  logic            w_signed_mode;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [W:0]      w_step_acc;
  logic [W-1:0]    w_step_a;
  logic [PW-1:0]   w_raw, w_raw_neg;

  // Constant-folds away when signed operation is disabled.
  assign w_signed_mode = SIGNED_EN ? io_bus.i_signed : 1'b0;
  assign w_a_mag   = W'(mag_of(MaxW'(io_bus.i_a), W, w_signed_mode));
  assign w_b_mag   = W'(mag_of(MaxW'(io_bus.i_b), W, w_signed_mode));
  assign w_raw     = {r_acc[W-1:0], r_a};
  assign w_raw_neg = PW'(neg2c(ProdMaxW'(w_raw)));

  sa_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sa_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_acc (w_step_acc),
    .o_a   (w_step_a)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_cnt_nxt     = r_cnt;
    w_neg_nxt     = r_neg;
    w_product_nxt = r_product;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.i_start) begin
          w_a_nxt     = w_a_mag;
          w_b_nxt     = w_b_mag;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_neg_nxt   = w_signed_mode & (io_bus.i_a[W-1] ^ io_bus.i_b[W-1]);
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_acc_nxt = w_step_acc;
        w_a_nxt   = w_step_a;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntLast) begin
          w_state_nxt = StFix;
        end
      end
      StFix: begin
        w_product_nxt = r_neg ? w_raw_neg : w_raw;
        w_done_nxt    = 1'b1;
        w_state_nxt   = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_cnt     <= w_cnt_nxt;
      r_neg     <= w_neg_nxt;
      r_product <= w_product_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign io_bus.o_busy    = (r_state != StIdle);
  assign io_bus.o_done    = r_done;
  assign io_bus.o_product = r_product;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Self-checking bench: W=8 signed, W=4 unsigned-only and W=16 signed instances vs. an arithmetic model.
module tb_shift_add_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_add_mult_seq_if #(.DATA_WIDTH(8))  bus8 ();
  shift_add_mult_seq_if #(.DATA_WIDTH(4))  bus4 ();
  shift_add_mult_seq_if #(.DATA_WIDTH(16)) bus16 ();

  shift_add_mult_seq #(.DATA_WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus8)
  );
  shift_add_mult_seq #(.DATA_WIDTH(4), .SIGNED_EN(1'b0)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus4)
  );
  shift_add_mult_seq #(.DATA_WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus16)
  );

  function automatic int wid(input int id);
    return (id == 0) ? 8 : (id == 1) ? 4 : 16;
  endfunction

  // Product as plain integer arithmetic, truncated to 2W bits.
  function automatic logic [63:0] ref_prod(input int id, input logic [15:0] a,
                                           input logic [15:0] b, input logic s);
    int     w;
    longint sa, sb, p;
    logic   sm;
    w  = wid(id);
    sm = s && (id != 1);
    sa = longint'(a) & ((64'sd1 <<< w) - 1);
    sb = longint'(b) & ((64'sd1 <<< w) - 1);
    if (sm && a[w-1]) sa = sa - (64'sd1 <<< w);
    if (sm && b[w-1]) sb = sb - (64'sd1 <<< w);
    p = sa * sb;
    return 64'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic s);
    case (id)
      0: begin bus8.i_start = st;  bus8.i_a = a[7:0];  bus8.i_b = b[7:0];  bus8.i_signed = s;  end
      1: begin bus4.i_start = st;  bus4.i_a = a[3:0];  bus4.i_b = b[3:0];  bus4.i_signed = s;  end
      default: begin
        bus16.i_start = st; bus16.i_a = a; bus16.i_b = b; bus16.i_signed = s;
      end
    endcase
  endtask

  task automatic set_start(input int id, input logic st);
    case (id)
      0: bus8.i_start = st;
      1: bus4.i_start = st;
      default: bus16.i_start = st;
    endcase
  endtask

  task automatic sample(input int id, output logic d, output logic bz, output logic [63:0] p);
    case (id)
      0: begin d = bus8.o_done;  bz = bus8.o_busy;  p = 64'(bus8.o_product);  end
      1: begin d = bus4.o_done;  bz = bus4.o_busy;  p = 64'(bus4.o_product);  end
      default: begin d = bus16.o_done; bz = bus16.o_busy; p = 64'(bus16.o_product); end
    endcase
  endtask

  // Issue one multiply and check latency, busy span, result and the single-cycle done pulse.
  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input string tag);
    logic        d, bz;
    logic [63:0] p, p_hold;
    int          cyc, busy_cnt;
    @(negedge clk);
    drive(id, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    set_start(id, 1'b0);
    cyc = 0;
    busy_cnt = 0;
    sample(id, d, bz, p);
    if (bz) busy_cnt++;
    while (!d && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      sample(id, d, bz, p);
      if (bz) busy_cnt++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(wid(id) + 1));
    chk({tag, "_product"}, p, ref_prod(id, a, b, s));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(wid(id) + 1));
    p_hold = p;
    @(posedge clk);
    #1;
    sample(id, d, bz, p);
    chk({tag, "_done_pulse"}, 64'(d), 64'(0));
    chk({tag, "_hold"}, p, p_hold);
  endtask

  initial begin
    logic        d, bz;
    logic [63:0] p;
    int          cyc, n_done;
    logic [15:0] ra, rb;
    logic        rs;

    for (int id = 0; id < 3; id++) drive(id, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      sample(id, d, bz, p);
      chk($sformatf("reset_busy%0d", id), 64'(bz), 64'(0));
      chk($sformatf("reset_done%0d", id), 64'(d), 64'(0));
      chk($sformatf("reset_prod%0d", id), p, 64'(0));
    end
    rst_n = 1'b1;

    run_op(0, 16'd255, 16'd255, 1'b0, "u255x255");
    chk("u255x255_const", ref_prod(0, 16'd255, 16'd255, 1'b0), 64'hFE01);
    run_op(0, 16'hFD, 16'd5, 1'b1, "s_m3x5");
    run_op(0, 16'h80, 16'h80, 1'b1, "s_m128xm128");
    run_op(0, 16'h80, 16'h7F, 1'b1, "s_m128x127");
    run_op(0, 16'h00, 16'hF9, 1'b1, "s_0xm7");

    // Start re-asserted during RUN must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 16'd7, 16'd6, 1'b0);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 16'd2, 16'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    set_start(0, 1'b0);
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      sample(0, d, bz, p);
      if (d) n_done++;
    end
    chk("ignore_start_ndone", 64'(n_done), 64'(1));
    chk("ignore_start_prod", p, 64'd42);

    // Reset in the middle of a run.
    @(negedge clk);
    drive(0, 1'b1, 16'd200, 16'd100, 1'b0);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample(0, d, bz, p);
    chk("midrst_busy", 64'(bz), 64'(0));
    chk("midrst_prod", p, 64'(0));
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      sample(0, d, bz, p);
      if (d) n_done++;
    end
    chk("midrst_no_done", 64'(n_done), 64'(0));

    // Back-to-back with start held high.
    @(negedge clk);
    drive(0, 1'b1, 16'd10, 16'd10, 1'b0);
    @(posedge clk);
    #1;
    cyc = 0;
    d = 1'b0;
    while (!d && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      sample(0, d, bz, p);
    end
    chk("b2b_first_lat", 64'(cyc), 64'd9);
    chk("b2b_first_prod", p, 64'd100);
    drive(0, 1'b1, 16'd3, 16'd3, 1'b0);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    cyc = 1;
    sample(0, d, bz, p);
    while (!d && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      sample(0, d, bz, p);
    end
    chk("b2b_period", 64'(cyc), 64'd10);
    chk("b2b_second_prod", p, 64'd9);

    // Parameter sweep corners.
    run_op(1, 16'd15, 16'd15, 1'b1, "w4_15x15");
    chk("w4_const", ref_prod(1, 16'd15, 16'd15, 1'b1), 64'd225);
    run_op(2, 16'h8000, 16'hFFFF, 1'b1, "w16_m32768xm1");
    chk("w16_const", ref_prod(2, 16'h8000, 16'hFFFF, 1'b1), 64'h0000_8000);

    // Randomized operands across all instances.
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op(i % 3, ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
